add_result_stage: RTL and testbench

//  Registered capture stage directly downstream of the yAdder datapath. Accepts
//  z/cout words with a valid/ready handshake, derives status flags, buffers up to
//  two results in a skid FIFO and presents them to the consumer with

---
 rtl/add_result_stage.sv | 98 +++++++++
 tb/tb_add_result_stage.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/add_result_stage.sv
// Registered capture stage behind the yAdder: 2-entry FIFO with per-entry status flags and a delivered-result counter.
// Optional signed-overflow flag storage is built only when ADD_OVF_FLAG_EN is defined.
module add_result_stage #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_z,
    input  logic             in_cout,
    input  logic             in_a_msb,
    input  logic             in_b_msb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_z,
    output logic             out_cout,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_ovf,
    output logic [CNT_W-1:0] res_count
);
    typedef struct packed {
        logic [WIDTH-1:0] z;
        logic             cout;
        logic             zero;
        logic             neg;
    } entry_t;

    entry_t     mem [2];
    entry_t     wr_ent;
    logic       wptr, rptr;
    logic [1:0] occ;
    logic       push, pop;

    // in_ready is a function of registered occupancy only, so no in_valid->in_ready loop
    assign in_ready  = (occ != 2'd2);
    assign out_valid = (occ != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        wr_ent      = '0;
        wr_ent.z    = in_z;
        wr_ent.cout = in_cout;
        wr_ent.zero = (in_z == '0);
        wr_ent.neg  = in_z[WIDTH-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0]    <= '0;
            mem[1]    <= '0;
            wptr      <= 1'b0;
            rptr      <= 1'b0;
            occ       <= 2'd0;
            res_count <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= wr_ent;
                wptr      <= ~wptr;
            end
            if (pop) begin
                rptr      <= ~rptr;
                res_count <= res_count + CNT_W'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    assign out_z    = mem[rptr].z;
    assign out_cout = mem[rptr].cout;
    assign out_zero = mem[rptr].zero;
    assign out_neg  = mem[rptr].neg;

`ifdef ADD_OVF_FLAG_EN
    logic [1:0] ovf_mem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf_mem <= 2'b00;
        else if (push)
            ovf_mem[wptr] <= (in_a_msb == in_b_msb) & (in_z[WIDTH-1] != in_a_msb);
    end

    assign out_ovf = ovf_mem[rptr];
`else
    logic unused_msb;

    assign unused_msb = in_a_msb ^ in_b_msb;
    assign out_ovf    = 1'b0;
`endif
endmodule

// File: tb/tb_add_result_stage.sv
// Scoreboard bench for add_result_stage: driver queues expected entries, a negedge monitor checks every pop.
module tb_add_result_stage;
    localparam int WIDTH = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_z = '0;
    logic             in_cout = 1'b0;
    logic             in_a_msb = 1'b0;
    logic             in_b_msb = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_z;
    logic             out_cout, out_zero, out_neg, out_ovf;
    logic [CNT_W-1:0] res_count;

    typedef struct {
        logic [WIDTH-1:0] z;
        logic             cout;
        logic             zero;
        logic             neg;
        logic             ovf;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_cnt = 0;

    add_result_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_z(in_z), .in_cout(in_cout), .in_a_msb(in_a_msb), .in_b_msb(in_b_msb),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_z(out_z), .out_cout(out_cout), .out_zero(out_zero),
        .out_neg(out_neg), .out_ovf(out_ovf), .res_count(res_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_ovf(input logic [WIDTH-1:0] z, input logic a, input logic b);
`ifdef ADD_OVF_FLAG_EN
        return (a == b) && (z[WIDTH-1] != a);
`else
        return 1'b0;
`endif
    endfunction

    // monitor: every handshake-completing cycle must match the oldest queued entry
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_pop", 64'(out_z), 64'hDEAD);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_z", 64'(out_z), 64'(e.z));
                chk("out_cout", 64'(out_cout), 64'(e.cout));
                chk("out_zero", 64'(out_zero), 64'(e.zero));
                chk("out_neg", 64'(out_neg), 64'(e.neg));
                chk("out_ovf", 64'(out_ovf), 64'(e.ovf));
            end
            exp_cnt++;
        end
    end

    task automatic send(input logic [WIDTH-1:0] z, input logic c, input logic a, input logic b,
                        input logic accept);
        exp_t e;
        @(posedge clk); #1;
        in_valid = 1'b1; in_z = z; in_cout = c; in_a_msb = a; in_b_msb = b;
        @(negedge clk);
        chk("in_ready", 64'(in_ready), 64'(accept));
        if (accept) begin
            e.z = z; e.cout = c; e.zero = (z == 0); e.neg = z[WIDTH-1];
            e.ovf = model_ovf(z, a, b);
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        int i;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        for (i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
        #2;
        chk("res_count", 64'(res_count), 64'(exp_cnt % 16));
        chk("empty_out_valid", 64'(out_valid), 64'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_res_count", 64'(res_count), 64'd0);
        chk("rst_out_z", 64'(out_z), 64'd0);
        chk("rst_flags", 64'({out_cout, out_zero, out_neg, out_ovf}), 64'd0);
        sb.delete();
        exp_cnt = 0;
        #2;
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        // power-on reset
        #1;
        chk("por_out_valid", 64'(out_valid), 64'd0);
        chk("por_res_count", 64'(res_count), 64'd0);
        #10 rst_n = 1'b1;
        #1 chk("por_in_ready", 64'(in_ready), 64'd1);

        // single pass
        out_ready = 1'b1;
        send(32'h0000_0005, 1'b0, 1'b0, 1'b0, 1'b1);
        drain();

        // backpressure: third beat dropped while full
        out_ready = 1'b0;
        send(32'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        send(32'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        send(32'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        chk("bp_head_z", 64'(out_z), 64'd1);
        drain();

        // flags
        out_ready = 1'b1;
        send(32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1);
        send(32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b1);
        send(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b1);
        send(32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b1);
        drain();

        // streaming: occupancy must stay at 1 so in_ready never drops
        out_ready = 1'b1;
        for (int k = 0; k < 100; k++) send(WIDTH'(k), k[0], k[1], k[2], 1'b1);
        drain();

        // reset with two entries in flight
        out_ready = 1'b0;
        send(32'hA, 1'b0, 1'b0, 1'b0, 1'b1);
        send(32'hB, 1'b1, 1'b0, 1'b0, 1'b1);
        do_reset();
        #1 chk("post_rst_out_valid", 64'(out_valid), 64'd0);

        // 17 pops on a 4-bit counter wraps to 1
        out_ready = 1'b1;
        for (int k = 0; k < 17; k++) send(WIDTH'(k + 200), 1'b0, 1'b0, 1'b0, 1'b1);
        drain();
        chk("wrap_res_count", 64'(res_count), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
